// File: rtl/vc_flit_driver_if.sv
// Valid/ready flit channel between a flit source and a router input port.
// The source drives one-hot VC, payload and valid; the sink returns ready.
interface vc_flit_driver_if #(
   parameter int VN = 4,
   parameter int DW = 32
);
   logic [VN-1:0] vc_o;
   logic [DW-1:0] data_o;
   logic          valid_o;
   logic          ready_i;

   modport master (
      output vc_o,
      output data_o,
      output valid_o,
      input  ready_i
   );

   modport slave (
      input  vc_o,
      input  data_o,
      input  valid_o,
      output ready_i
   );
endinterface

// File: rtl/vc_flit_driver.sv
// Flit source for router-port testing: injects NUM_FLITS self-describing flits
// per VC, round-robin across VCs, with an optional idle gap after each transfer.
module vc_flit_driver #(
   parameter int PORT      = 0,
   parameter int VN        = 4,
   parameter int DW        = 32,
   parameter int NUM_FLITS = 1000,
   parameter int GAP       = 0
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start_i,
   vc_flit_driver_if.master flit_if,
   output logic             done
);

   localparam int          CW       = (NUM_FLITS < 1) ? 1 : $clog2(NUM_FLITS + 1);
   localparam int          PW       = $clog2(VN);
   localparam logic [CW:0] NF_L     = (CW + 1)'(NUM_FLITS);
   localparam logic [3:0]  PORT4    = 4'(PORT);
   localparam logic [7:0]  GAP_INIT = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND,
      ST_GAP,
      ST_DONE
   } state_t;

   state_t          state_q, state_d;
   logic            valid_q, valid_d;
   logic [VN-1:0]   vc_q, vc_d;
   logic [DW-1:0]   data_q, data_d;
   logic            done_q, done_d;
   logic [7:0]      gap_cnt_q, gap_cnt_d;
   logic [PW-1:0]   cur_q, cur_d;
   logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]   cnt_q [VN];
   logic [CW-1:0]   cnt_d [VN];

   logic            xfer;
   logic [CW-1:0]   cnt_post [VN];
   logic [PW-1:0]   rr_post;
   logic [VN-1:0]   elig;
   logic            any_elig;
   logic            found;
   logic [PW:0]     idx;
   logic [PW-1:0]   sel;
   logic [VN-1:0]   flit_vc;
   logic [DW-1:0]   flit_data;

   // Counters and pointer as they will be after this cycle's transfer, so the
   // next flit can be picked back-to-back without a bubble.
   always_comb begin
      xfer     = (state_q == ST_SEND) && valid_q && flit_if.ready_i;
      cnt_post = cnt_q;
      rr_post  = rr_ptr_q;
      if (xfer) begin
         cnt_post[cur_q] = cnt_q[cur_q] + CW'(1);
         rr_post         = (cur_q == PW'(VN - 1)) ? '0 : cur_q + PW'(1);
      end
   end

   // First eligible VC at or after the round-robin pointer, wrapping at VN.
   always_comb begin
      elig = '0;
      for (int v = 0; v < VN; v++) begin
         elig[v] = ({1'b0, cnt_post[v]} < NF_L);
      end
      any_elig = |elig;
      found    = 1'b0;
      sel      = '0;
      idx      = '0;
      for (int i = 0; i < VN; i++) begin
         idx = {1'b0, rr_post} + (PW + 1)'(i);
         if (idx >= (PW + 1)'(VN)) begin
            idx = idx - (PW + 1)'(VN);
         end
         if (!found && elig[idx[PW-1:0]]) begin
            found = 1'b1;
            sel   = idx[PW-1:0];
         end
      end
      flit_vc                = '0;
      flit_vc[sel]           = 1'b1;
      flit_data              = '0;
      flit_data[DW-1 -: 4]   = PORT4;
      flit_data[DW-5 -: 4]   = 4'(sel);
      flit_data[15:0]        = 16'(cnt_post[sel]);
   end

   always_comb begin
      state_d   = state_q;
      valid_d   = valid_q;
      vc_d      = vc_q;
      data_d    = data_q;
      done_d    = done_q;
      gap_cnt_d = gap_cnt_q;
      cur_d     = cur_q;
      rr_ptr_d  = rr_ptr_q;
      cnt_d     = cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               if (!any_elig) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_SEND;
                  valid_d = 1'b1;
                  vc_d    = flit_vc;
                  data_d  = flit_data;
                  cur_d   = sel;
               end
            end
         end

         ST_SEND: begin
            if (xfer) begin
               cnt_d    = cnt_post;
               rr_ptr_d = rr_post;
               if (!any_elig) begin
                  state_d = ST_DONE;
                  valid_d = 1'b0;
                  vc_d    = '0;
                  data_d  = '0;
                  done_d  = 1'b1;
               end else if (GAP > 0) begin
                  state_d   = ST_GAP;
                  valid_d   = 1'b0;
                  gap_cnt_d = GAP_INIT;
               end else begin
                  valid_d = 1'b1;
                  vc_d    = flit_vc;
                  data_d  = flit_data;
                  cur_d   = sel;
               end
            end
         end

         ST_GAP: begin
            if (gap_cnt_q == 8'd0) begin
               state_d = ST_SEND;
               valid_d = 1'b1;
               vc_d    = flit_vc;
               data_d  = flit_data;
               cur_d   = sel;
            end else begin
               gap_cnt_d = gap_cnt_q - 8'd1;
            end
         end

         ST_DONE: begin
            valid_d = 1'b0;
            vc_d    = '0;
            done_d  = 1'b1;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= ST_IDLE;
         valid_q   <= 1'b0;
         vc_q      <= '0;
         data_q    <= '0;
         done_q    <= 1'b0;
         gap_cnt_q <= '0;
         cur_q     <= '0;
         rr_ptr_q  <= '0;
         for (int v = 0; v < VN; v++) begin
            cnt_q[v] <= '0;
         end
      end else begin
         state_q   <= state_d;
         valid_q   <= valid_d;
         vc_q      <= vc_d;
         data_q    <= data_d;
         done_q    <= done_d;
         gap_cnt_q <= gap_cnt_d;
         cur_q     <= cur_d;
         rr_ptr_q  <= rr_ptr_d;
         cnt_q     <= cnt_d;
      end
   end

   assign flit_if.vc_o    = vc_q;
   assign flit_if.data_o  = data_q;
   assign flit_if.valid_o = valid_q;
   assign done            = done_q;

endmodule

// File: tb/tb_vc_flit_driver.sv
// Directed bench for vc_flit_driver: four configurations cover back-to-back
// injection, backpressure, idle gaps, async reset, long runs and zero flits.
module tb_vc_flit_driver;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rstn;
   logic start_a, start_b, start_c, start_d;
   logic done_a, done_b, done_c, done_d;

   int n_asserts = 0;
   int n_fails   = 0;
   int exp_cnt_d [3];
   int exp_vc_d;

   vc_flit_driver_if #(.VN(4), .DW(32)) if_a ();
   vc_flit_driver_if #(.VN(4), .DW(32)) if_b ();
   vc_flit_driver_if #(.VN(4), .DW(32)) if_c ();
   vc_flit_driver_if #(.VN(3), .DW(32)) if_d ();

   vc_flit_driver #(.PORT(5), .VN(4), .DW(32), .NUM_FLITS(3), .GAP(0)) dut_a (
      .clk(clk), .rstn(rstn), .start_i(start_a), .flit_if(if_a), .done(done_a));
   vc_flit_driver #(.PORT(0), .VN(4), .DW(32), .NUM_FLITS(3), .GAP(2)) dut_b (
      .clk(clk), .rstn(rstn), .start_i(start_b), .flit_if(if_b), .done(done_b));
   vc_flit_driver #(.PORT(0), .VN(4), .DW(32), .NUM_FLITS(0), .GAP(0)) dut_c (
      .clk(clk), .rstn(rstn), .start_i(start_c), .flit_if(if_c), .done(done_c));
   vc_flit_driver #(.PORT(0), .VN(3), .DW(32), .NUM_FLITS(1000), .GAP(0)) dut_d (
      .clk(clk), .rstn(rstn), .start_i(start_d), .flit_if(if_d), .done(done_d));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fails++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input int which, input logic start, input logic ready);
      case (which)
         0: begin start_a = start; if_a.ready_i = ready; end
         1: begin start_b = start; if_b.ready_i = ready; end
         2: begin start_c = start; if_c.ready_i = ready; end
         default: begin start_d = start; if_d.ready_i = ready; end
      endcase
   endtask

   function automatic logic [31:0] flit_word(input int port, input int vc, input int seq);
      return {4'(port), 4'(vc), 8'h00, 16'(seq)};
   endfunction

   // Full-system reset pulse placed between clock edges.
   task automatic pulse_reset();
      #2;
      rstn = 1'b0;
      #2;
      rstn = 1'b1;
      tick();
   endtask

   task automatic reset_model_d();
      for (int v = 0; v < 3; v++) exp_cnt_d[v] = 0;
      exp_vc_d = 0;
   endtask

   // Sink for instance d: ready high one cycle in every ready_every, each
   // accepted flit compared against round-robin order and per-VC sequence.
   task automatic sink_d(input int max_xfers, input int ready_every, input int budget);
      int nx;
      int cyc;
      nx  = 0;
      cyc = 0;
      while (nx < max_xfers && cyc < budget) begin
         if_d.ready_i = ((cyc % ready_every) == 0);
         if (if_d.valid_o && if_d.ready_i) begin
            checkOutput("d_flit", 64'({if_d.vc_o, if_d.data_o}),
                        64'({3'(1 << exp_vc_d), flit_word(0, exp_vc_d, exp_cnt_d[exp_vc_d])}));
            exp_cnt_d[exp_vc_d]++;
            exp_vc_d = (exp_vc_d + 1) % 3;
            nx++;
         end
         tick();
         cyc++;
      end
      checkOutput("d_xfer_count", 64'(nx), 64'(max_xfers));
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rstn = 1'b0;
      for (int w = 0; w < 4; w++) applyStimulus(w, 1'b0, 1'b0);
      reset_model_d();

      // Reset state
      #12;
      checkOutput("rst_valid_a", 64'(if_a.valid_o), 64'd0);
      checkOutput("rst_vc_a",    64'(if_a.vc_o),    64'd0);
      checkOutput("rst_data_a",  64'(if_a.data_o),  64'd0);
      checkOutput("rst_done_a",  64'(done_a),       64'd0);
      checkOutput("rst_valid_d", 64'(if_d.valid_o), 64'd0);
      rstn = 1'b1;
      tick();

      // T1: back-to-back, round-robin, done after 12th transfer
      $display("[TB] T1 back-to-back injection");
      applyStimulus(0, 1'b1, 1'b1);
      tick();
      applyStimulus(0, 1'b0, 1'b1);
      for (int k = 0; k < 12; k++) begin
         checkOutput("t1_valid", 64'(if_a.valid_o), 64'd1);
         checkOutput("t1_flit", 64'({if_a.vc_o, if_a.data_o}),
                     64'({4'(1 << (k % 4)), flit_word(5, k % 4, k / 4)}));
         tick();
      end
      checkOutput("t1_done",  64'(done_a),       64'd1);
      checkOutput("t1_valid_end", 64'(if_a.valid_o), 64'd0);
      checkOutput("t1_vc_end",    64'(if_a.vc_o),    64'd0);

      // T6: zero flits goes straight to done
      $display("[TB] T6 NUM_FLITS=0");
      checkOutput("t6_done_pre", 64'(done_c), 64'd0);
      applyStimulus(2, 1'b1, 1'b1);
      tick();
      applyStimulus(2, 1'b0, 1'b1);
      checkOutput("t6_done", 64'(done_c), 64'd1);
      for (int i = 0; i < 3; i++) begin
         checkOutput("t6_valid", 64'(if_c.valid_o), 64'd0);
         tick();
      end

      // T5: async reset mid-run, then sequence numbers restart
      $display("[TB] T5 async reset mid-run");
      applyStimulus(3, 1'b1, 1'b1);
      tick();
      applyStimulus(3, 1'b0, 1'b1);
      reset_model_d();
      sink_d(50, 1, 100);
      checkOutput("t5_done_mid", 64'(done_d), 64'd0);
      #2;
      rstn = 1'b0;
      #1;
      checkOutput("t5_valid_async", 64'(if_d.valid_o), 64'd0);
      checkOutput("t5_vc_async",    64'(if_d.vc_o),    64'd0);
      checkOutput("t5_data_async",  64'(if_d.data_o),  64'd0);
      checkOutput("t5_done_a_async", 64'(done_a), 64'd0);
      checkOutput("t5_done_c_async", 64'(done_c), 64'd0);
      #2;
      rstn = 1'b1;
      tick();
      checkOutput("t5_idle_valid", 64'(if_d.valid_o), 64'd0);
      applyStimulus(3, 1'b1, 1'b1);
      tick();
      applyStimulus(3, 1'b0, 1'b1);
      reset_model_d();
      sink_d(3, 1, 10);

      // T4: sparse ready over a full 1000-flit-per-VC run
      $display("[TB] T4 sparse ready, full run");
      pulse_reset();
      reset_model_d();
      applyStimulus(3, 1'b1, 1'b0);
      tick();
      start_d = 1'b0;
      sink_d(3000, 3, 12000);
      checkOutput("t4_done",  64'(done_d),       64'd1);
      checkOutput("t4_valid", 64'(if_d.valid_o), 64'd0);

      // T2: backpressure holds the flit stable with no duplicate
      $display("[TB] T2 backpressure");
      pulse_reset();
      applyStimulus(0, 1'b1, 1'b0);
      tick();
      applyStimulus(0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         checkOutput("t2_hold_valid", 64'(if_a.valid_o), 64'd1);
         checkOutput("t2_hold_flit", 64'({if_a.vc_o, if_a.data_o}),
                     64'({4'b0001, flit_word(5, 0, 0)}));
         tick();
      end
      applyStimulus(0, 1'b0, 1'b1);
      checkOutput("t2_release_flit", 64'({if_a.vc_o, if_a.data_o}),
                  64'({4'b0001, flit_word(5, 0, 0)}));
      tick();
      for (int k = 1; k < 5; k++) begin
         checkOutput("t2_next_flit", 64'({if_a.vc_o, if_a.data_o}),
                     64'({4'(1 << (k % 4)), flit_word(5, k % 4, k / 4)}));
         tick();
      end

      // T3: GAP=2 gives a 1,0,0 valid pattern over 34 cycles
      $display("[TB] T3 idle gap");
      pulse_reset();
      applyStimulus(1, 1'b1, 1'b1);
      tick();
      applyStimulus(1, 1'b0, 1'b1);
      for (int c = 0; c < 34; c++) begin
         checkOutput("t3_valid", 64'(if_b.valid_o), 64'((c % 3) == 0));
         if ((c % 3) == 0) begin
            checkOutput("t3_flit", 64'({if_b.vc_o, if_b.data_o}),
                        64'({4'(1 << ((c / 3) % 4)), flit_word(0, (c / 3) % 4, (c / 3) / 4)}));
         end
         tick();
      end
      checkOutput("t3_done",  64'(done_b),       64'd1);
      checkOutput("t3_valid_end", 64'(if_b.valid_o), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
      $finish;
   end

endmodule
